lsu_subword: RTL and testbench
==============================

# lsu_subword

Load/store adapter between the core's memory-stage request and the word-wide single-port data RAM (asynchronous read, synchronous write, no byte enables). Word loads and stores pass through in one cycle. Byte/halfword loads are extracted and extended. Byte/halfword stores are done as a two-cycle read-modify-write, because the RAM has no byte enables. The block also flags misaligned and reserved-size accesses.

## Interface
- DataWidth, 32, data word width; only 32 is supported.
- NPos, 1024, RAM depth in words.
- NPosWidth, $clog2(NPos), localparam: RAM address width.

- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  memory access request valid.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- unsigned_i  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rdata_o  out  32  load result, extended to 32 bits.
- ready_o  out  1  access completes this cycle; core stalls while req_i=1 and ready_o=0.
- err_o  out  1  misaligned or reserved-size access, valid with ready_o.
- ram_a_o  out  NPosWidth  RAM word address.
- ram_we_o  out  1  RAM write enable.
- ram_wd_o  out  32  RAM write data.
- ram_rd_i  in  32  RAM asynchronous read data.

## Operation
- Word index = addr_i[NPosWidth+1:2]. Address bits above that are ignored, so addresses wrap modulo NPos words. Lane = addr_i[1:0].
- Error conditions:
  - Misaligned: halfword with addr_i[0]=1, or word with addr_i[1:0]≠00.
  - Reserved: size_i=11.
  - On error: err_o=1, ready_o=1 in the same cycle, ram_we_o=0, rdata_o=0, no state change.
- FSM with states IDLE and RMW_WR.
- IDLE:
  - ram_a_o = word index of addr_i.
  - No request (req_i=0): ready_o=0, ram_we_o=0.
  - Load: ready_o=1 combinationally. rdata_o = selected lane of ram_rd_i (byte lane k = bits [8k+7:8k]; halfword lane = addr_i[1]), extended per unsigned_i. Word load returns ram_rd_i unchanged.
  - Word store: ram_we_o=1, ram_wd_o=wdata_i, ready_o=1; stay in IDLE.
  - Byte/halfword store:
    - Cycle outputs: ram_we_o=0, ready_o=0.
    - At the clock edge, register old_q←ram_rd_i, idx_q←word index, lane_q←addr_i[1:0], size_q←size_i, data_q←wdata_i.
    - Go to RMW_WR.
- RMW_WR:
  - ram_a_o=idx_q, ram_we_o=1, ready_o=1.
  - ram_wd_o = old_q with the addressed byte or halfword replaced by data_q[7:0] or data_q[15:0]; all other bytes unchanged.
  - All core inputs are ignored in this state.
  - Return to IDLE unconditionally.
- The merge path is registered on purpose: there is no combinational path from ram_rd_i to ram_wd_o or ram_we_o.
- The core must hold all request inputs stable while ready_o=0.

## Timing
- Reset: while rst_i=1, the FSM is forced to IDLE and ram_we_o=0, ready_o=0, err_o=0, rdata_o=0. A reset asserted in RMW_WR suppresses that write; no RAM location changes.
- Load latency: 0 cycles (combinational through the asynchronous RAM read).
- Word store: 1 cycle; the RAM updates at the rising edge ending the request cycle.
- Sub-word store: 2 cycles.
  - Cycle N: IDLE, read.
  - Cycle N+1: RMW_WR, write; the RAM updates at the edge ending N+1.
  - ready_o is high only in N+1.
- Back-to-back sub-word stores: a new request is accepted in the cycle after RMW_WR, giving one store per 2 cycles. A load issued directly after an RMW to the same word returns the merged value.
- Registers old_q, idx_q, lane_q, size_q and data_q need no reset; they are only consumed in RMW_WR.

## Test plan
- Word round-trip: store 0xDEADBEEF to addr 0x10, then load word from 0x10 → rdata_o=0xDEADBEEF, ready_o=1 in each request cycle, err_o=0.
- Byte store RMW: RAM[4]=0x11223344; store byte 0xAA to addr 0x12 → cycle 1 ready_o=0 and ram_we_o=0; cycle 2 ram_a_o=4, ram_wd_o=0x11AA3344, ram_we_o=1; RAM[4] is then 0x11AA3344.
- Extension: RAM[0]=0x80FF7F01; load byte at 0x1 signed → 0x0000007F; load byte at 0x2 signed → 0xFFFFFFFF; load halfword at 0x2 unsigned → 0x000080FF; load halfword at 0x2 signed → 0xFFFF80FF.
- Errors: halfword store to 0x3, word load from 0x2, and size 11 each → err_o=1, ready_o=1, ram_we_o=0, RAM unchanged.
- Reset mid-RMW: halfword store to 0x20, then assert rst_i in the RMW_WR cycle → ram_we_o=0, RAM[8] unchanged, FSM in IDLE; the next request is serviced normally.
- Wrap and back-to-back: NPos=1024, byte stores to 0x1000 then 0x1001 with 0x55 and 0x66 (word 0 after wrap) → RAM[0][15:0]=0x6655, 4 cycles total.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store adapter for a word-wide, byte-enable-less data RAM.
// Word accesses pass straight through; byte/halfword stores use a two-cycle read-modify-write.
module lsu_subword #(
  parameter int DataWidth = 32,
  parameter int NPos      = 1024,
  localparam int NPosWidth = $clog2(NPos)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [31:0]          addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 ready_o,
  output logic                 err_o,
  output logic [NPosWidth-1:0] ram_a_o,
  output logic                 ram_we_o,
  output logic [DataWidth-1:0] ram_wd_o,
  input  logic [DataWidth-1:0] ram_rd_i,
  output logic                 dbg_state_o
);

  // Handshake: an access completes in the cycle where req_i=1 and ready_o=1;
  // the core holds every request input stable while req_i=1 and ready_o=0.

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q;

  logic [NPosWidth-1:0] idx_q;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic [15:0]          data_q;
  logic [DataWidth-1:0] old_q;

  logic [NPosWidth-1:0] idx;
  logic [1:0]           lane;
  logic                 acc_err;
  logic                 start_rmw;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DataWidth-1:0] ld_data;
  logic [DataWidth-1:0] merged;
  logic                 unused_addr;

  assign idx         = addr_i[NPosWidth+1:2];
  assign lane        = addr_i[1:0];
  assign unused_addr = ^addr_i[31:NPosWidth+2];
  assign dbg_state_o = (state_q == RMW_WR);

  assign acc_err = (size_i == 2'b11)
                 || ((size_i == SZ_HALF) && addr_i[0])
                 || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));

  always_comb begin
    ld_byte = 8'h00;
    case (lane)
      2'd0: ld_byte = ram_rd_i[7:0];
      2'd1: ld_byte = ram_rd_i[15:8];
      2'd2: ld_byte = ram_rd_i[23:16];
      default: ld_byte = ram_rd_i[31:24];
    endcase
    ld_half = lane[1] ? ram_rd_i[31:16] : ram_rd_i[15:0];
    ld_data = ram_rd_i;
    if (size_i == SZ_BYTE) begin
      ld_data = {{24{ld_byte[7] & ~unsigned_i}}, ld_byte};
    end else if (size_i == SZ_HALF) begin
      ld_data = {{16{ld_half[15] & ~unsigned_i}}, ld_half};
    end
  end

  // Merge operates only on registered data, so ram_rd_i never reaches ram_wd_o combinationally.
  always_comb begin
    merged = old_q;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  always_comb begin
    ready_o   = 1'b0;
    err_o     = 1'b0;
    ram_we_o  = 1'b0;
    ram_wd_o  = wdata_i;
    ram_a_o   = idx;
    rdata_o   = '0;
    start_rmw = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (acc_err) begin
              err_o   = 1'b1;
              ready_o = 1'b1;
            end else if (!we_i) begin
              ready_o = 1'b1;
              rdata_o = ld_data;
            end else if (size_i == SZ_WORD) begin
              ram_we_o = 1'b1;
              ready_o  = 1'b1;
            end else begin
              start_rmw = 1'b1;
            end
          end
        end
        default: begin
          ram_a_o  = idx_q;
          ram_we_o = 1'b1;
          ram_wd_o = merged;
          ready_o  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_rmw) state_q <= RMW_WR;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture registers are only consumed in RMW_WR, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (start_rmw) begin
      old_q  <= ram_rd_i;
      idx_q  <= idx;
      lane_q <= lane;
      size_q <= size_i;
      data_q <= wdata_i[15:0];
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed self-checking bench for lsu_subword with a behavioural async-read RAM.
module tb_lsu_subword;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        err_o;
  logic [9:0]  ram_a_o;
  logic        ram_we_o;
  logic [31:0] ram_wd_o;
  logic [31:0] ram_rd_i;
  logic        dbg_state_o;

  logic [31:0] ram [0:1023];
  logic [31:0] exp_q[$];
  logic [31:0] snap;
  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  lsu_subword dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .ready_o(ready_o), .err_o(err_o), .ram_a_o(ram_a_o), .ram_we_o(ram_we_o),
    .ram_wd_o(ram_wd_o), .ram_rd_i(ram_rd_i), .dbg_state_o(dbg_state_o)
  );

  assign ram_rd_i = ram[ram_a_o];
  always @(posedge clk_i) if (ram_we_o) ram[ram_a_o] <= ram_wd_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    #1;
  endtask

  task automatic idle();
    req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, sz, uns, a, 32'h0);
    check({tag, "_rdata"}, rdata_o, exp);
    check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    step();
    idle();
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [9:0] w);
    snap = ram[w];
    drive(we, sz, 1'b0, a, 32'hA5A5_5A5A);
    check({tag, "_err"}, {31'b0, err_o}, 32'd1);
    check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    check({tag, "_we"}, {31'b0, ram_we_o}, 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    step();
    idle();
    #1;
    check({tag, "_state"}, {31'b0, dbg_state_o}, 32'd0);
    check({tag, "_ram"}, ram[w], snap);
  endtask

  int cycles;
  int done;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    rst_i = 1'b1;
    idle();
    step();
    // load request during reset must be suppressed
    ram[0] = 32'h1234_5678;
    drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_we", {31'b0, ram_we_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    step();
    idle();
    rst_i = 1'b0;
    step();

    // word round-trip
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("wst_ready", {31'b0, ready_o}, 32'd1);
    check("wst_we", {31'b0, ram_we_o}, 32'd1);
    check("wst_err", {31'b0, err_o}, 32'd0);
    check("wst_addr", {22'b0, ram_a_o}, 32'd4);
    step();
    idle();
    load_chk("wld", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

    // byte store read-modify-write
    ram[4] = 32'h1122_3344;
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    check("bst_c1_ready", {31'b0, ready_o}, 32'd0);
    check("bst_c1_we", {31'b0, ram_we_o}, 32'd0);
    step();
    check("bst_c2_state", {31'b0, dbg_state_o}, 32'd1);
    check("bst_c2_ready", {31'b0, ready_o}, 32'd1);
    check("bst_c2_we", {31'b0, ram_we_o}, 32'd1);
    check("bst_c2_addr", {22'b0, ram_a_o}, 32'd4);
    check("bst_c2_wd", ram_wd_o, 32'h11AA_3344);
    step();
    idle();
    check("bst_ram", ram[4], 32'h11AA_3344);

    // extension
    ram[0] = 32'h80FF_7F01;
    load_chk("lb1s", 2'b00, 1'b0, 32'h1, 32'h0000_007F);
    load_chk("lb2s", 2'b00, 1'b0, 32'h2, 32'hFFFF_FFFF);
    load_chk("lh2u", 2'b01, 1'b1, 32'h2, 32'h0000_80FF);
    load_chk("lh2s", 2'b01, 1'b0, 32'h2, 32'hFFFF_80FF);
    load_chk("lb3u", 2'b00, 1'b1, 32'h3, 32'h0000_0080);
    load_chk("lb0s", 2'b00, 1'b0, 32'h0, 32'h0000_0001);
    load_chk("lh0s", 2'b01, 1'b0, 32'h0, 32'h0000_7F01);

    // errors
    err_chk("e_hst3", 1'b1, 2'b01, 32'h3, 10'd0);
    err_chk("e_wld2", 1'b0, 2'b10, 32'h2, 10'd0);
    err_chk("e_rsv", 1'b1, 2'b11, 32'h0, 10'd0);

    // reset in RMW_WR suppresses the write
    ram[8] = 32'hCAFE_F00D;
    drive(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_1234);
    step();
    rst_i = 1'b1;
    #1;
    check("rrmw_we", {31'b0, ram_we_o}, 32'd0);
    check("rrmw_ready", {31'b0, ready_o}, 32'd0);
    step();
    rst_i = 1'b0;
    idle();
    #1;
    check("rrmw_state", {31'b0, dbg_state_o}, 32'd0);
    check("rrmw_ram", ram[8], 32'hCAFE_F00D);
    load_chk("rrmw_ld", 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);

    // halfword store followed directly by a load of the same word
    drive(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234);
    step();
    check("hst_wd", ram_wd_o, 32'h1234_F00D);
    step();
    load_chk("hst_ld", 2'b10, 1'b0, 32'h20, 32'h1234_F00D);

    // wrap and back-to-back byte stores into word 0
    cycles = 0;
    done = 0;
    drive(1'b1, 2'b00, 1'b0, 32'h1000, 32'h55);
    while (done < 2 && cycles < 10) begin
      cycles++;
      if (ready_o) begin
        check("wrap_addr", {22'b0, ram_a_o}, 32'd0);
        done++;
        if (done == 1) begin
          req_i = 1'b1; addr_i = 32'h1001; wdata_i = 32'h66;
        end
      end
      step();
    end
    idle();
    check("wrap_done", done, 32'd2);
    check("wrap_cycles", cycles, 32'd4);
    check("wrap_ram", {16'b0, ram[0][15:0]}, 32'h0000_6655);

    // scoreboard: final RAM image
    exp_q.push_back(32'h80FF_6655);
    exp_q.push_back(32'h11AA_3344);
    exp_q.push_back(32'h1234_F00D);
    for (int w = 0; w < 3; w++) check("final_ram", ram[w * 4], exp_q.pop_front());

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end

endmodule
